// File: rtl/dstack_spill_if.sv
// Memory-side bus of the dstack spill/fill engine: one outstanding request,
// held until acknowledged. The engine is the master, the memory the slave.
interface dstack_spill_if #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0]      mem_wdata;
   logic                  mem_ack;
   logic [WIDTH-1:0]      mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/dstack_spill.sv
// Spill/fill engine below the register dstack: a one-word cache in front of a memory-backed LIFO.
// Define DSTACK_SPILL_PREFETCH_EN to refill the cache from memory as soon as a fill empties it.
module dstack_spill #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int SPILL_MAG  = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  spill_valid,
   input  logic [WIDTH-1:0]      spill_data,
   output logic                  spill_ready,
   input  logic                  fill_req,
   output logic                  fill_ready,
   output logic [WIDTH-1:0]      fill_data,
   dstack_spill_if.master        mem,
   output logic [SPILL_MAG:0]    count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] READ  = 2'd2;

   localparam logic [SPILL_MAG:0] SP_ONE = (SPILL_MAG + 1)'(1);
   localparam logic [SPILL_MAG:0] SP_CAP = SP_ONE << SPILL_MAG;

   logic [1:0]            state;
   logic [SPILL_MAG:0]    sp;
   logic [WIDTH-1:0]      cache;
   logic                  cache_valid;
   logic                  req_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WIDTH-1:0]      wdata_q;
   logic [ADDR_WIDTH-1:0] push_addr;
   logic [ADDR_WIDTH-1:0] pop_addr;
   logic                  is_idle;

   assign is_idle     = (state == IDLE);
   assign spill_ready = is_idle;
   assign fill_ready  = is_idle && (cache_valid || spill_valid);
   // A simultaneous spill and fill hands the incoming word straight back.
   assign fill_data   = spill_valid ? spill_data : cache;
   assign count       = sp + {{SPILL_MAG{1'b0}}, cache_valid};

   assign push_addr = base_addr + ADDR_WIDTH'(sp);
   assign pop_addr  = base_addr + ADDR_WIDTH'(sp - SP_ONE);

   assign mem.mem_req   = req_q;
   assign mem.mem_we    = we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   // Single state machine owning the cache, the memory pointer and the memory request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         sp          <= '0;
         cache       <= '0;
         cache_valid <= 1'b0;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
         case (state)
            IDLE: begin
               if (spill_valid && !fill_req) begin
                  cache       <= spill_data;
                  cache_valid <= 1'b1;
                  if (cache_valid) begin
                     if (sp != SP_CAP) begin
                        req_q   <= 1'b1;
                        we_q    <= 1'b1;
                        addr_q  <= push_addr;
                        wdata_q <= cache;
                        state   <= WRITE;
                     end else begin
                        overflow <= 1'b1;
                     end
                  end
               end else if (fill_req && !spill_valid) begin
                  if (cache_valid) begin
                     cache_valid <= 1'b0;
`ifdef DSTACK_SPILL_PREFETCH_EN
                     if (sp != '0) begin
                        req_q  <= 1'b1;
                        we_q   <= 1'b0;
                        addr_q <= pop_addr;
                        state  <= READ;
                     end
`endif
                  end else if (sp == '0) begin
                     underflow <= 1'b1;
                  end else begin
                     // Cache miss: the requester keeps fill_req high until the read lands.
                     req_q  <= 1'b1;
                     we_q   <= 1'b0;
                     addr_q <= pop_addr;
                     state  <= READ;
                  end
               end
            end
            WRITE: begin
               if (mem.mem_ack) begin
                  req_q <= 1'b0;
                  sp    <= sp + SP_ONE;
                  state <= IDLE;
               end
            end
            READ: begin
               if (mem.mem_ack) begin
                  req_q       <= 1'b0;
                  cache       <= mem.mem_rdata;
                  cache_valid <= 1'b1;
                  sp          <= sp - SP_ONE;
                  state       <= IDLE;
               end
            end
            default: begin
               req_q <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
